// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer placed directly after the UART receiver. Each push
// strobe stores one received byte in a first-word-fall-through FIFO. The host
// pops bytes with a single-cycle read strobe. A sticky flag records bytes that
// were lost because the FIFO was full.
//
// Parameters
//   D_BIT   data word width (matches the receiver's data width)
//   ADDR_W  address width; the FIFO depth is 2**ADDR_W entries
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   wr        in   push strobe (receiver rx_done_tick), one push per high cycle
//   w_data    in   byte to push, sampled only when wr=1
//   rd        in   pop strobe, one pop per high cycle
//   ovf_clr   in   clears the sticky overflow flag
//   r_data    out  head-of-FIFO word, valid whenever empty=0
//   empty     out  no entries stored
//   full      out  2**ADDR_W entries stored
//   level     out  number of stored entries, 0..2**ADDR_W
//   overflow  out  sticky, set when a push is dropped
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int D_BIT  = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [D_BIT-1:0]  w_data,
   input  logic              rd,
   input  logic              ovf_clr,
   output logic [D_BIT-1:0]  r_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overflow
);

   localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] LVL_ZERO  = (ADDR_W+1)'(0);
   localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [D_BIT-1:0]  mem_r [2**ADDR_W];
   logic [ADDR_W-1:0] wp_r;
   logic [ADDR_W-1:0] rp_r;
   logic [ADDR_W:0]   level_r;
   logic              empty_r;
   logic              full_r;
   logic              overflow_r;

   logic              push_ok_s;
   logic              pop_ok_s;
   logic              drop_s;
   logic [ADDR_W:0]   level_nxt_s;

   // Decode which of the requested operations actually take effect this cycle.
   // A push into a full FIFO is still accepted when a pop frees the head slot
   // in the same cycle; a pop on an empty FIFO is ignored even if a push
   // arrives alongside it (no bypass).
   always_comb begin
      push_ok_s = wr & (~full_r | rd);
      pop_ok_s  = rd & ~empty_r;
      drop_s    = wr & full_r & ~rd;
   end

   // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Storage array; deliberately not reset, contents are qualified by level.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wp_r] <= w_data;
      end
   end

   // Pointers, occupancy and the flags derived from it, all registered so the
   // flags never glitch and have no combinational path from wr/rd.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_r    <= '0;
         rp_r    <= '0;
         level_r <= LVL_ZERO;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wp_r <= wp_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rp_r <= rp_r + PTR_ONE;
         end
         level_r <= level_nxt_s;
         empty_r <= (level_nxt_s == LVL_ZERO);
         full_r  <= (level_nxt_s == DEPTH);
      end
   end

   // Sticky overflow: a dropped push wins over a coincident clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (ovf_clr) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign r_data   = mem_r[rp_r];
   assign empty    = empty_r;
   assign full     = full_r;
   assign level    = level_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed self-checking bench for uart_rx_fifo. Inputs are driven 1 ns after
// the rising edge and outputs are sampled 1 ns after the rising edge, once the
// registered state has settled.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   logic       clk;
   logic       rst;
   logic       wr;
   logic [7:0] w_data;
   logic       rd;
   logic       ovf_clr;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic [4:0] level;
   logic       overflow;

   int n_checks;
   int n_fails;
   logic [7:0] sb_q[$];
   logic [7:0] next_val;

   uart_rx_fifo #(.D_BIT(8), .ADDR_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .w_data   (w_data),
      .rd       (rd),
      .ovf_clr  (ovf_clr),
      .r_data   (r_data),
      .empty    (empty),
      .full     (full),
      .level    (level),
      .overflow (overflow)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of strobes, then return the inputs to idle.
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr      = w;
      w_data  = d;
      rd      = r;
      ovf_clr = c;
      @(posedge clk);
      #1;
      wr      = 1'b0;
      rd      = 1'b0;
      ovf_clr = 1'b0;
   endtask

   task automatic fill_seq(input logic [7:0] base);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, base + 8'(i), 1'b0, 1'b0);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst      = 1'b0;
      wr       = 1'b0;
      w_data   = 8'h00;
      rd       = 1'b0;
      ovf_clr  = 1'b0;

      // Power-on reset.
      repeat (3) @(posedge clk);
      #1;
      check_val("por_level", 32'(level), 32'd0);
      check_val("por_empty", 32'(empty), 32'd1);
      check_val("por_full", 32'(full), 32'd0);
      check_val("por_ovf", 32'(overflow), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Mid-stream asynchronous reset with 5 entries stored.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      end
      check_val("pre_rst_level", 32'(level), 32'd5);
      #2;
      rst = 1'b0;
      #1;
      check_val("rst_level", 32'(level), 32'd0);
      check_val("rst_empty", 32'(empty), 32'd1);
      check_val("rst_full", 32'(full), 32'd0);
      check_val("rst_ovf", 32'(overflow), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      check_val("post_rst_rdata", 32'(r_data), 32'h3C);
      check_val("post_rst_level", 32'(level), 32'd1);
      check_val("post_rst_empty", 32'(empty), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("post_rst_drain", 32'(empty), 32'd1);

      // Ordering.
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      check_val("ord_level3", 32'(level), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check_val("ord_rdata", 32'(r_data), 32'(8'h11 * (i + 1)));
         check_val("ord_level", 32'(level), 32'(3 - i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_val("ord_level0", 32'(level), 32'd0);
      check_val("ord_empty", 32'(empty), 32'd1);

      // Fill and overflow.
      fill_seq(8'h00);
      check_val("fill_full", 32'(full), 32'd1);
      check_val("fill_level", 32'(level), 32'd16);
      check_val("fill_ovf0", 32'(overflow), 32'd0);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      check_val("drop_ovf", 32'(overflow), 32'd1);
      check_val("drop_level", 32'(level), 32'd16);
      check_val("drop_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check_val("drain_rdata", 32'(r_data), 32'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_val("drain_empty", 32'(empty), 32'd1);
      check_val("drain_ovf_sticky", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_val("ovf_clr", 32'(overflow), 32'd0);

      // Simultaneous push and pop while full.
      fill_seq(8'h00);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      check_val("simf_level", 32'(level), 32'd16);
      check_val("simf_ovf", 32'(overflow), 32'd0);
      check_val("simf_rdata", 32'(r_data), 32'h01);
      for (int i = 1; i < 16; i++) begin
         check_val("simf_drain", 32'(r_data), 32'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_val("simf_last", 32'(r_data), 32'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("simf_empty", 32'(empty), 32'd1);

      // Simultaneous push and pop while empty, pop on empty, clear priority.
      step(1'b1, 8'h77, 1'b1, 1'b0);
      check_val("sime_level", 32'(level), 32'd1);
      check_val("sime_rdata", 32'(r_data), 32'h77);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("sime_pop_level", 32'(level), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_val("pop_empty_level", 32'(level), 32'd0);
      check_val("pop_empty_empty", 32'(empty), 32'd1);
      check_val("pop_empty_ovf", 32'(overflow), 32'd0);
      fill_seq(8'h40);
      step(1'b1, 8'h99, 1'b0, 1'b1);
      check_val("clr_prio_ovf", 32'(overflow), 32'd1);
      check_val("clr_prio_level", 32'(level), 32'd16);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_val("clr_after", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) begin
         check_val("clr_drain", 32'(r_data), 32'(8'h40 + 8'(i)));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_val("clr_drain_empty", 32'(empty), 32'd1);

      // Pointer wrap with interleaved push/pop pairs, level kept in 2..3.
      next_val = 8'h80;
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back(next_val);
         step(1'b1, next_val, 1'b0, 1'b0);
         next_val = next_val + 8'h01;
      end
      for (int i = 0; i < 40; i++) begin
         sb_q.push_back(next_val);
         step(1'b1, next_val, 1'b0, 1'b0);
         next_val = next_val + 8'h01;
         check_val("wrap_level_hi", 32'(level), 32'd3);
         check_val("wrap_rdata", 32'(r_data), 32'(sb_q.pop_front()));
         step(1'b0, 8'h00, 1'b1, 1'b0);
         check_val("wrap_level_lo", 32'(level), 32'd2);
      end
      check_val("wrap_ovf", 32'(overflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
